// File: rtl/calc_pkg.sv
// Shared constants for the calculator datapath: FSM state encoding and
// the default operand width.
package calc_pkg;

  localparam int CALC_W = 4;

  // Encoding 2'd3 is unused; the controller treats it as IDLE.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {A,Qr} left, trial-subtract the divisor,
// keep the difference and set the quotient bit when it does not go negative.
module div_step
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_W
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] qr,
  input  logic [WIDTH-1:0] mr,
  output logic [WIDTH:0]   a_nx,
  output logic [WIDTH-1:0] qr_nx
);

  logic [WIDTH:0] sh_s;
  logic [WIDTH:0] diff_s;
  logic           ge_s;

  // A bit shifted out of the top of A means the partial remainder already
  // exceeds any W-bit divisor, so the subtract always succeeds.
  always_comb begin
    sh_s   = {a[WIDTH-1:0], qr[WIDTH-1]};
    ge_s   = a[WIDTH] | (sh_s >= {1'b0, mr});
    diff_s = sh_s - {1'b0, mr};
    if (ge_s) begin
      a_nx  = diff_s;
      qr_nx = {qr[WIDTH-2:0], 1'b1};
    end else begin
      a_nx  = sh_s;
      qr_nx = {qr[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequential restoring divider controller: start/busy/done handshake, one
// quotient bit per clock, results zero-extended to 2W bits.
module div_seq_ctrl
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero,
  output logic [2*WIDTH-1:0]   quotient,
  output logic [2*WIDTH-1:0]   remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]         state_r;
  logic [1:0]         state_nx_s;
  logic [WIDTH:0]     a_r;
  logic [WIDTH-1:0]   qr_r;
  logic [WIDTH-1:0]   mr_r;
  logic [CW-1:0]      count_r;
  logic [WIDTH:0]     a_nx_s;
  logic [WIDTH-1:0]   qr_nx_s;
  logic               busy_s;
  logic               done_s;
  logic               busy_r;
  logic               done_r;
  logic               dbz_r;
  logic [2*WIDTH-1:0] quo_r;
  logic [2*WIDTH-1:0] rem_r;
  logic               last_step_s;

  div_step #(.WIDTH(WIDTH)) u_step (
    .a     (a_r),
    .qr    (qr_r),
    .mr    (mr_r),
    .a_nx  (a_nx_s),
    .qr_nx (qr_nx_s)
  );

  assign last_step_s = (count_r <= CW'(1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nx_s;
  end

  // Next-state logic
  always_comb begin
    state_nx_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nx_s = (divisor == {WIDTH{1'b0}}) ? ST_DONE : ST_RUN;
        else       state_nx_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last_step_s) state_nx_s = ST_DONE;
        else             state_nx_s = ST_RUN;
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so busy/done can be registered
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_nx_s)
      ST_RUN:  busy_s = 1'b1;
      ST_DONE: begin
        busy_s = 1'b1;
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Handshake output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
    end
  end

  // Datapath: operand load, iteration and result latch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r     <= {(WIDTH+1){1'b0}};
      qr_r    <= {WIDTH{1'b0}};
      mr_r    <= {WIDTH{1'b0}};
      count_r <= {CW{1'b0}};
      dbz_r   <= 1'b0;
      quo_r   <= {(2*WIDTH){1'b0}};
      rem_r   <= {(2*WIDTH){1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && (divisor != {WIDTH{1'b0}})) begin
            a_r     <= {(WIDTH+1){1'b0}};
            qr_r    <= dividend;
            mr_r    <= divisor;
            count_r <= CW'(WIDTH);
            dbz_r   <= 1'b0;
            quo_r   <= {(2*WIDTH){1'b0}};
            rem_r   <= {(2*WIDTH){1'b0}};
          end else if (start) begin
            dbz_r   <= 1'b1;
            quo_r   <= {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
            rem_r   <= {{WIDTH{1'b0}}, dividend};
          end
        end
        ST_RUN: begin
          a_r     <= a_nx_s;
          qr_r    <= qr_nx_s;
          count_r <= count_r - CW'(1);
          if (last_step_s) begin
            quo_r <= {{WIDTH{1'b0}}, qr_nx_s};
            rem_r <= {{WIDTH{1'b0}}, a_nx_s[WIDTH-1:0]};
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dbz_r;
  assign quotient    = quo_r;
  assign remainder   = rem_r;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl (WIDTH=4): directed vector table,
// multi-cycle corner sequences, random and exhaustive operand sweeps.
module tb_div_seq_ctrl;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   dividend;
  logic [W-1:0]   divisor;
  logic           busy;
  logic           done;
  logic           div_by_zero;
  logic [2*W-1:0] quotient;
  logic [2*W-1:0] remainder;

  int pass_cnt = 0;
  int total_cnt = 0;

  div_seq_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] q;
    logic [2*W-1:0] r;
    logic           dbz;
    int             lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // Reference: plain unsigned division with the divide-by-zero rule
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [2*W-1:0] q, output logic [2*W-1:0] r,
                       output logic dbz);
    int ai = int'(a);
    int bi = int'(b);
    if (bi == 0) begin
      q = 8'h0F;
      r = 8'(ai);
      dbz = 1'b1;
    end else begin
      q = 8'(ai / bi);
      r = 8'(ai % bi);
      dbz = 1'b0;
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Full operation: accept, wait for done, check results, latency and teardown
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] eq, input logic [2*W-1:0] er,
                       input logic edbz, input int elat, input string tag);
    int lat = 0;
    issue(a, b);
    check({tag, ".busy_rise"}, 32'(busy), 32'd1);
    if (b != 4'd0) check({tag, ".clear_on_accept"}, {23'd0, div_by_zero, quotient}, 32'd0);
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(elat));
    check({tag, ".quotient"}, 32'(quotient), 32'(eq));
    check({tag, ".remainder"}, 32'(remainder), 32'(er));
    check({tag, ".dbz"}, 32'(div_by_zero), 32'(edbz));
    check({tag, ".busy_at_done"}, 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check({tag, ".done_pulse_end"}, {30'd0, done, busy}, 32'd0);
    check({tag, ".hold"}, {15'd0, div_by_zero, quotient, remainder},
          {15'd0, edbz, eq, er});
  endtask

  initial begin
    logic [2*W-1:0] mq, mr;
    logic           mdbz;
    int             pulses;
    logic [2*W-1:0] cq, cr;

    vecs[0] = '{4'd15, 4'd15, 8'h01, 8'h00, 1'b0, 4};
    vecs[1] = '{4'd8,  4'd2,  8'h04, 8'h00, 1'b0, 4};
    vecs[2] = '{4'd7,  4'd3,  8'h02, 8'h01, 1'b0, 4};
    vecs[3] = '{4'd9,  4'd0,  8'h0F, 8'h09, 1'b1, 0};
    vecs[4] = '{4'd13, 4'd4,  8'h03, 8'h01, 1'b0, 4};
    vecs[5] = '{4'd0,  4'd5,  8'h00, 8'h00, 1'b0, 4};
    vecs[6] = '{4'd15, 4'd1,  8'h0F, 8'h00, 1'b0, 4};
    vecs[7] = '{4'd1,  4'd15, 8'h00, 8'h01, 1'b0, 4};

    rst_n = 1'b0;
    start = 1'b0;
    dividend = 4'd0;
    divisor = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {21'd0, busy, done, div_by_zero, quotient},
          32'd0);
    check("reset_rem", 32'(remainder), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table; entries 1/2 run back-to-back, 3 then 4 shows dbz clearing
    for (int i = 0; i < 8; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz,
            vecs[i].lat, $sformatf("vec%0d", i));

    // start held high, operands changed mid-run: exactly one result for 5/1
    @(negedge clk);
    dividend = 4'd5;
    divisor = 4'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    dividend = 4'd6;
    divisor = 4'd2;
    pulses = 0;
    cq = 8'hEE;
    cr = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        cq = quotient;
        cr = remainder;
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("held.pulses", 32'(pulses), 32'd1);
    check("held.quotient", 32'(cq), 32'h05);
    check("held.remainder", 32'(cr), 32'h00);
    check("held.idle", 32'(busy), 32'd0);

    // Reset on edge k+2 of 13/4 discards the operation
    issue(4'd13, 4'd4);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst.outputs", {21'd0, busy, done, div_by_zero, quotient}, 32'd0);
    check("midrst.rem", 32'(remainder), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) pulses++;
    end
    check("midrst.no_done", 32'(pulses), 32'd0);
    do_op(4'd13, 4'd4, 8'h03, 8'h01, 1'b0, 4, "midrst.fresh");

    // Reset and start on the same edge: reset wins
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    dividend = 4'd6;
    divisor = 4'd3;
    @(posedge clk);
    #1;
    check("rst_vs_start", {30'd0, busy, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;

    // Random operands against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      model(ra, rb, mq, mr, mdbz);
      do_op(ra, rb, mq, mr, mdbz, mdbz ? 0 : W, $sformatf("rand%0d", i));
    end

    // Exhaustive sweep with the invariants checked directly
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        model(4'(a), 4'(b), mq, mr, mdbz);
        do_op(4'(a), 4'(b), mq, mr, mdbz, mdbz ? 0 : W, $sformatf("sw%0d_%0d", a, b));
        if (b != 0) begin
          check($sformatf("inv%0d_%0d", a, b),
                32'(int'(quotient) * b + int'(remainder)), 32'(a));
          check($sformatf("rlt%0d_%0d", a, b), 32'(int'(remainder) < b), 32'd1);
        end
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
